// File: rtl/instruction_fetch_pkg.sv
// Shared types and constants for the fetch stage and the decoder it feeds.
package instruction_fetch_pkg;

    localparam int unsigned XLEN    = 32;
    localparam int unsigned JIMM_W  = 28;
    localparam int unsigned BRIMM_W = 16;

    localparam logic [XLEN-1:0] INSTR_NOP = 32'h0000_0000;

    typedef enum logic [1:0] {
        PC_SRC_NEXT   = 2'd0,
        PC_SRC_REG    = 2'd1,
        PC_SRC_JUMP   = 2'd2,
        PC_SRC_BRANCH = 2'd3
    } pc_src_e;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        ISSUE = 2'd2,
        HALT  = 2'd3
    } fetch_state_e;

    // Word-offset branch immediate -> signed byte offset.
    function automatic logic [XLEN-1:0] br_offset(input logic [BRIMM_W-1:0] imm);
        return {{14{imm[BRIMM_W-1]}}, imm, 2'b00};
    endfunction

endpackage

// File: rtl/instruction_fetch_if.sv
// Fetch-stage bundle: decoder controls, instruction-memory port and fetch outputs.
interface instruction_fetch_if;
    import instruction_fetch_pkg::*;

    logic [1:0]         pcSrc;
    logic [JIMM_W-1:0]  jImm;
    logic [BRIMM_W-1:0] brImm;
    logic [XLEN-1:0]    regA;
    logic               stall;
    logic               imemReq;
    logic [XLEN-1:0]    imemAddr;
    logic               imemAck;
    logic [XLEN-1:0]    imemData;
    logic [XLEN-1:0]    instruction;
    logic               instrValid;
    logic [XLEN-1:0]    pc;
    logic [XLEN-1:0]    pcPlus4;
    logic               fault;

    modport master (
        input  pcSrc, jImm, brImm, regA, stall, imemAck, imemData,
        output imemReq, imemAddr, instruction, instrValid, pc, pcPlus4, fault
    );

    modport slave (
        output pcSrc, jImm, brImm, regA, stall, imemAck, imemData,
        input  imemReq, imemAddr, instruction, instrValid, pc, pcPlus4, fault
    );

endinterface

// File: rtl/instruction_fetch_next_pc_calc.sv
// Combinational next-PC selection; flags jr targets that are not word aligned.
module next_pc_calc
    import instruction_fetch_pkg::*;
(
    input  logic [XLEN-1:0]    pc_i,
    input  pc_src_e            pc_src_i,
    input  logic [JIMM_W-1:0]  j_imm_i,
    input  logic [BRIMM_W-1:0] br_imm_i,
    input  logic [XLEN-1:0]    reg_a_i,
    output logic [XLEN-1:0]    next_pc_o,
    output logic               misaligned_o
);

    logic [XLEN-1:0] pc_plus4;

    assign pc_plus4 = pc_i + XLEN'(4);

    always_comb begin
        next_pc_o    = pc_plus4;
        misaligned_o = 1'b0;
        case (pc_src_i)
            PC_SRC_NEXT:   next_pc_o = pc_plus4;
            PC_SRC_REG: begin
                next_pc_o    = reg_a_i;
                misaligned_o = |reg_a_i[1:0];
            end
            PC_SRC_JUMP:   next_pc_o = {pc_plus4[XLEN-1:JIMM_W], j_imm_i};
            PC_SRC_BRANCH: next_pc_o = pc_plus4 + br_offset(br_imm_i);
            default:       next_pc_o = pc_plus4;
        endcase
    end

endmodule

// File: rtl/instruction_fetch.sv
// Fetch stage: PC register, req/ack instruction fetch, decode hand-off and
// sticky fault on fetch timeout or misaligned jr target.
module instruction_fetch
    import instruction_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int unsigned MAX_WAIT   = 8,
    parameter int unsigned DECODE_LAT = 1
) (
    input  logic                clk,
    input  logic                reset,
    instruction_fetch_if.master bus
);

    localparam int unsigned WAIT_W = $clog2(MAX_WAIT + 1);
    localparam int unsigned DEC_W  = $clog2(DECODE_LAT + 1);

    fetch_state_e      state_q, state_d;
    logic [XLEN-1:0]   pc_q, pc_d;
    logic [XLEN-1:0]   instr_q, instr_d;
    logic              valid_q, valid_d;
    logic              req_q, req_d;
    logic              fault_q, fault_d;
    logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic [DEC_W-1:0]  dec_cnt_q, dec_cnt_d;

    logic [XLEN-1:0]   next_pc;
    logic              misaligned;

    next_pc_calc u_next_pc_calc (
        .pc_i         (pc_q),
        .pc_src_i     (pc_src_e'(bus.pcSrc)),
        .j_imm_i      (bus.jImm),
        .br_imm_i     (bus.brImm),
        .reg_a_i      (bus.regA),
        .next_pc_o    (next_pc),
        .misaligned_o (misaligned)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            pc_q       <= RESET_PC;
            instr_q    <= INSTR_NOP;
            valid_q    <= 1'b0;
            req_q      <= 1'b0;
            fault_q    <= 1'b0;
            wait_cnt_q <= '0;
            dec_cnt_q  <= '0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            instr_q    <= instr_d;
            valid_q    <= valid_d;
            req_q      <= req_d;
            fault_q    <= fault_d;
            wait_cnt_q <= wait_cnt_d;
            dec_cnt_q  <= dec_cnt_d;
        end
    end

    // Next state; an ack takes priority over a timeout in the same cycle.
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        instr_d    = instr_q;
        valid_d    = valid_q;
        req_d      = req_q;
        fault_d    = fault_q;
        wait_cnt_d = wait_cnt_q;
        dec_cnt_d  = dec_cnt_q;
        case (state_q)
            IDLE: begin
                state_d    = REQ;
                req_d      = 1'b1;
                wait_cnt_d = '0;
            end
            REQ: begin
                if (bus.imemAck) begin
                    instr_d   = bus.imemData;
                    valid_d   = 1'b1;
                    dec_cnt_d = '0;
                    req_d     = 1'b0;
                    state_d   = ISSUE;
                end else if (wait_cnt_q == WAIT_W'(MAX_WAIT - 1)) begin
                    fault_d = 1'b1;
                    req_d   = 1'b0;
                    state_d = HALT;
                end else begin
                    wait_cnt_d = wait_cnt_q + WAIT_W'(1);
                end
            end
            ISSUE: begin
                if (!bus.stall) begin
                    if (dec_cnt_q == DEC_W'(DECODE_LAT - 1)) begin
                        valid_d = 1'b0;
                        if (misaligned) begin
                            fault_d = 1'b1;
                            state_d = HALT;
                        end else begin
                            pc_d       = next_pc;
                            req_d      = 1'b1;
                            wait_cnt_d = '0;
                            state_d    = REQ;
                        end
                    end else begin
                        dec_cnt_d = dec_cnt_q + DEC_W'(1);
                    end
                end
            end
            HALT: begin
                state_d = HALT;
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.imemReq     = req_q;
    assign bus.imemAddr    = pc_q;
    assign bus.instruction = instr_q;
    assign bus.instrValid  = valid_q;
    assign bus.pc          = pc_q;
    assign bus.pcPlus4     = pc_q + XLEN'(4);
    assign bus.fault       = fault_q;

endmodule

// File: tb/tb_instruction_fetch.sv
// Bench for instruction_fetch: directed scenarios followed by randomized
// instruction streams checked against a transaction-level PC model.
module tb_instruction_fetch;
    import instruction_fetch_pkg::*;

    localparam logic [31:0] RST_PC = 32'h0000_0000;
    localparam int unsigned MW     = 8;
    localparam int unsigned DL     = 1;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    instruction_fetch_if bus ();

    instruction_fetch #(
        .RESET_PC   (RST_PC),
        .MAX_WAIT   (MW),
        .DECODE_LAT (DL)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int          n_chk  = 0;
    int          n_fail = 0;
    logic [31:0] exp_pc;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        @(negedge clk);
    endtask

    function automatic logic [31:0] ref_next(input logic [31:0] cur, input logic [1:0] src,
                                             input logic [27:0] j, input logic [15:0] b,
                                             input logic [31:0] a);
        logic [31:0] r;
        int          off;
        off = $signed(b);
        off = off * 4;
        case (src)
            2'd0:    r = cur + 32'd4;
            2'd1:    r = a;
            2'd2:    r = ((cur + 32'd4) & 32'hF000_0000) | {4'h0, j};
            default: r = cur + 32'd4 + 32'(off);
        endcase
        return r;
    endfunction

    task automatic rand_ctrl;
        bus.pcSrc = 2'($urandom);
        bus.jImm  = 28'($urandom);
        bus.brImm = 16'($urandom);
        bus.regA  = $urandom;
    endtask

    task automatic do_reset;
        reset = 1'b1;
        bus.imemAck = 1'b0;
        bus.stall = 1'b0;
        step;
        step;
        reset = 1'b0;
        step;
        exp_pc = RST_PC;
        chk("reset_fault_clear", 32'(bus.fault), 32'd0);
    endtask

    // One instruction: wait `delay` REQ cycles, ack, stall, then decode.
    task automatic do_instr(input logic [31:0] word, input int delay, input int stalls,
                            input logic [1:0] src, input logic [27:0] j,
                            input logic [15:0] b, input logic [31:0] a,
                            output bit halted);
        halted = 1'b0;
        chk("req_start", 32'(bus.imemReq), 32'd1);
        chk("req_addr", bus.imemAddr, exp_pc);
        for (int k = 0; k < delay; k++) begin
            bus.imemAck = 1'b0;
            bus.imemData = $urandom;
            rand_ctrl();
            step;
            chk("req_wait", 32'(bus.imemReq), 32'd1);
        end
        bus.imemAck = 1'b1;
        bus.imemData = word;
        step;
        bus.imemAck = 1'b0;
        bus.imemData = $urandom;
        chk("issue_valid", 32'(bus.instrValid), 32'd1);
        chk("issue_instr", bus.instruction, word);
        chk("issue_req_low", 32'(bus.imemReq), 32'd0);
        chk("issue_pc", bus.pc, exp_pc);
        chk("issue_pc4", bus.pcPlus4, exp_pc + 32'd4);
        chk("issue_nofault", 32'(bus.fault), 32'd0);
        bus.stall = 1'b1;
        for (int k = 0; k < stalls; k++) begin
            rand_ctrl();
            step;
            chk("stall_instr", bus.instruction, word);
            chk("stall_pc", bus.pc, exp_pc);
            chk("stall_req", 32'(bus.imemReq), 32'd0);
            chk("stall_valid", 32'(bus.instrValid), 32'd1);
        end
        bus.stall = 1'b0;
        bus.pcSrc = src;
        bus.jImm  = j;
        bus.brImm = b;
        bus.regA  = a;
        repeat (DL) step;
        if (src == 2'd1 && a[1:0] != 2'b00) begin
            halted = 1'b1;
            chk("jr_fault", 32'(bus.fault), 32'd1);
            chk("jr_req_low", 32'(bus.imemReq), 32'd0);
            chk("jr_pc_hold", bus.pc, exp_pc);
        end else begin
            exp_pc = ref_next(exp_pc, src, j, b, a);
            chk("next_valid_low", 32'(bus.instrValid), 32'd0);
            chk("next_req", 32'(bus.imemReq), 32'd1);
            chk("next_addr", bus.imemAddr, exp_pc);
        end
    endtask

    // Entered in the first REQ cycle: no ack must give exactly MW request cycles.
    task automatic run_timeout;
        int n;
        n = 0;
        bus.imemAck = 1'b0;
        while (bus.imemReq === 1'b1 && n < int'(MW) + 4) begin
            n++;
            step;
        end
        chk("timeout_len", 32'(n), 32'(MW));
        chk("timeout_fault", 32'(bus.fault), 32'd1);
        chk("timeout_req_low", 32'(bus.imemReq), 32'd0);
        bus.imemAck = 1'b1;
        bus.imemData = $urandom;
        repeat (2) step;
        bus.imemAck = 1'b0;
        chk("halt_valid", 32'(bus.instrValid), 32'd0);
        chk("halt_fault", 32'(bus.fault), 32'd1);
    endtask

    initial begin
        bit          h;
        logic [31:0] held;
        int          delay, stalls;
        logic [1:0]  src;
        logic [31:0] a;

        bus.pcSrc = 2'd0;
        bus.jImm = '0;
        bus.brImm = '0;
        bus.regA = '0;
        bus.stall = 1'b0;
        bus.imemAck = 1'b0;
        bus.imemData = '0;
        exp_pc = RST_PC;
        @(negedge clk);
        step;
        step;
        chk("rst_req", 32'(bus.imemReq), 32'd0);
        chk("rst_valid", 32'(bus.instrValid), 32'd0);
        chk("rst_fault", 32'(bus.fault), 32'd0);
        chk("rst_pc", bus.pc, RST_PC);
        chk("rst_instr", bus.instruction, 32'h0);
        chk("rst_pc4", bus.pcPlus4, RST_PC + 32'd4);
        reset = 1'b0;
        step;
        chk("first_req", 32'(bus.imemReq), 32'd1);
        chk("first_addr", bus.imemAddr, 32'h0);

        do_instr(32'h2008_0005, 0, 0, 2'd0, '0, '0, '0, h);
        chk("seq_pc4", bus.pc, 32'h4);

        do_instr($urandom, 0, 0, 2'd2, 28'h000_0010, '0, '0, h);
        do_instr($urandom, 1, 0, 2'd3, '0, 16'hFFFE, '0, h);
        chk("branch_back", bus.imemAddr, 32'h0000_000C);
        do_instr($urandom, 0, 0, 2'd1, '0, '0, 32'h0000_0010, h);
        do_instr($urandom, 0, 0, 2'd3, '0, 16'h0003, '0, h);
        chk("branch_fwd", bus.imemAddr, 32'h0000_0020);

        do_instr($urandom, 0, 0, 2'd1, '0, '0, 32'h0040_0020, h);
        bus.imemAck = 1'b1;
        bus.imemData = 32'h1234_5678;
        step;
        bus.imemAck = 1'b0;
        chk("jump_pc4", bus.pcPlus4, 32'h0040_0024);
        bus.pcSrc = 2'd2;
        bus.jImm = 28'h010_0040;
        step;
        exp_pc = 32'h0010_0040;
        chk("jump_addr", bus.imemAddr, 32'h0010_0040);

        do_instr(32'hCAFE_0001, 0, 3, 2'd0, '0, '0, '0, h);
        chk("stall_then_seq", bus.imemAddr, 32'h0010_0044);
        do_instr(32'hBEEF_0002, int'(MW) - 1, 0, 2'd0, '0, '0, '0, h);
        chk("late_ack_nofault", 32'(bus.fault), 32'd0);

        // Reset during REQ, then an ack arriving while in IDLE.
        held = bus.instruction;
        reset = 1'b1;
        step;
        chk("midreq_req_low", 32'(bus.imemReq), 32'd0);
        chk("midreq_pc", bus.pc, RST_PC);
        chk("midreq_instr", bus.instruction, 32'h0);
        reset = 1'b0;
        bus.imemAck = 1'b1;
        bus.imemData = held ^ 32'hFFFF_FFFF;
        step;
        bus.imemAck = 1'b0;
        chk("idle_ack_ignored_valid", 32'(bus.instrValid), 32'd0);
        chk("idle_ack_ignored_instr", bus.instruction, 32'h0);
        exp_pc = RST_PC;

        do_instr($urandom, 0, 0, 2'd1, '0, '0, 32'h0000_0080, h);
        chk("jr_ok", bus.pc, 32'h0000_0080);
        do_instr($urandom, 0, 0, 2'd1, '0, '0, 32'h0000_0082, h);
        chk("jr_halted", 32'(h), 32'd1);
        repeat (3) step;
        chk("jr_fault_sticky", 32'(bus.fault), 32'd1);
        chk("jr_req_stays_low", 32'(bus.imemReq), 32'd0);
        chk("jr_pc_sticky", bus.pc, 32'h0000_0080);
        do_reset();

        run_timeout();
        do_reset();

        for (int it = 0; it < 300; it++) begin
            if ($urandom_range(0, 31) == 0) begin
                run_timeout();
                do_reset();
            end else begin
                delay  = $urandom_range(0, MW - 1);
                stalls = $urandom_range(0, 3);
                src    = 2'($urandom);
                a      = $urandom;
                if ($urandom_range(0, 15) != 0) a[1:0] = 2'b00;
                do_instr($urandom, delay, stalls, src, 28'($urandom), 16'($urandom), a, h);
                if (h) do_reset();
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/instruction_fetch.md
Name: instruction_fetch

Overview:
Upstream stage of the instruction decoder. Holds the PC and fetches one instruction word per step over a req/ack instruction-memory port. Presents the word to the decoder with a valid flag, then computes the next PC from the decoder's pcSrc, jImm and branch immediate.
Timeouts and misaligned jump-register targets raise a sticky fault and halt fetch.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset
MAX_WAIT, 8, max cycles in REQ without imemAck before fault (>=1)
DECODE_LAT, 1, cycles instrValid is held before decoder controls are sampled (>=1; matches the clocked decoder)

Ports:
clk  in  1  system clock, rising edge
reset  in  1  synchronous, active-high reset
pcSrc  in  2  next-PC select from decoder: 0 pc+4, 1 reg (jr), 2 jump absolute, 3 branch
jImm  in  28  jump target (instr[25:0]<<2) from decoder
brImm  in  16  branch immediate from decoder (signed, word offset)
regA  in  32  rs register value, jr target
stall  in  1  hold current instruction; no PC update
imemReq  out  1  fetch request
imemAddr  out  32  fetch address (= pc)
imemAck  in  1  memory has imemData valid this cycle
imemData  in  32  fetched word
instruction  out  32  word to decoder
instrValid  out  1  instruction is valid
pc  out  32  address of current instruction
pcPlus4  out  32  pc+4 (jal writeback source)
fault  out  1  sticky: fetch timeout or misaligned jr

Behaviour:
- Reset (sync, active-high; wins over all inputs):
  - State IDLE, pc=RESET_PC, instruction=0, instrValid=0, imemReq=0, fault=0, both counters 0.
  - Reset asserted mid-fetch abandons the request. An ack arriving in IDLE is ignored.
- All outputs are registered except: imemAddr=pc, and pcPlus4=pc+4 (mod 2^32).
- States:
  - IDLE -> REQ unconditionally next cycle.
  - REQ: imemReq=1.
    - On imemAck: latch imemData into instruction, set instrValid=1, decCnt=0, go to ISSUE. imemReq falls at the same edge.
    - If no ack: waitCnt++. No ack for MAX_WAIT consecutive REQ cycles -> go to HALT, fault=1, imemReq=0.
    - waitCnt clears on entering REQ.
  - ISSUE: instrValid=1.
    - decCnt increments on each non-stalled cycle.
    - On the cycle decCnt==DECODE_LAT-1 with stall=0: sample pcSrc/jImm/brImm/regA, load pc=nextPc, instrValid=0, go to REQ.
    - stall=1 freezes decCnt, pc and instruction.
  - HALT: all outputs hold. fault=1 until reset.
- nextPc (32-bit, wrap modulo 2^32, no overflow detection):
  - 0: pc+4
  - 1: regA. If regA[1:0]!=0 -> HALT, fault=1, pc unchanged.
  - 2: {pcPlus4[31:28], jImm}
  - 3: pcPlus4 + (sext32(brImm)<<2)
- Minimum throughput: 1 (REQ with immediate ack) + DECODE_LAT cycles per instruction.
- Simultaneous events:
  - stall together with the final ISSUE cycle -> stall wins.
  - imemAck on the same cycle the timeout would fire -> ack wins, no fault.

Decomposition:
- Shared package:
  - PC_SRC_NEXT/REG/JUMP/BRANCH (2-bit), shared with the decoder.
  - Fetch state enum IDLE/REQ/ISSUE/HALT.
  - INSTR_NOP = 32'h0.
- One combinational sub-module next_pc_calc (pc, pcSrc, jImm, brImm, regA -> nextPc, misaligned).
- FSM, counters and registers stay in instruction_fetch.

Test Plan:
- Reset then immediate ack with imemData=32'h2008_0005 -> imemReq high cycle 1 with imemAddr=0. instruction=32'h2008_0005, instrValid=1 next cycle. pc=4 after DECODE_LAT=1 cycle with pcSrc=0.
- Branch: pc=0x10, pcSrc=3, brImm=16'hFFFE -> next imemAddr=0x0C. brImm=16'h0003 -> 0x20.
- Jump: pc=0x0040_0020, pcSrc=2, jImm=28'h010_0040 -> next imemAddr=0x0010_0040. pcPlus4=0x0040_0024 during ISSUE.
- jr: pcSrc=1, regA=0x80 -> next pc=0x80. regA=0x82 -> fault=1, imemReq stays 0, pc holds, until reset clears fault.
- Timeout, MAX_WAIT=8: no ack -> imemReq high exactly 8 cycles, then fault=1, imemReq=0. Ack on the 8th cycle instead -> no fault, word latched.
- Stall 3 cycles during ISSUE -> instruction and pc unchanged, no request issued. Fetch of pc+4 starts the cycle after stall drops. Reset asserted during REQ -> imemReq=0 next cycle, pc=RESET_PC, late ack ignored.
